// File: rtl/uart_core_param_if.sv
// Handshake bundle between system logic and uart_core_param.
// master = system side, slave = UART side.
interface uart_core_param_if #(
  parameter int DATA_BITS     = 8,
  parameter int RX_FIFO_DEPTH = 16
);
  localparam int CW = $clog2(RX_FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic                 rx_err_clr;
  logic [CW-1:0]        rx_fifo_count;

  modport master (
    output tx_data, tx_valid, rx_ready, rx_err_clr,
    input  tx_ready, tx_busy, rx_data, rx_frame_err,
    input  rx_parity_err, rx_valid, rx_overrun, rx_fifo_count
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready, rx_err_clr,
    output tx_ready, tx_busy, rx_data, rx_frame_err,
    output rx_parity_err, rx_valid, rx_overrun, rx_fifo_count
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised UART: 16x tick divider, TX FSM, oversampled RX FSM
// with majority vote and false-start rejection, RX FIFO.
module uart_core_param #(
  parameter int SYSTEM_CLOCK  = 99999001,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic system_clk,
  input  logic reset,
  output logic tx,
  input  logic rx,
  uart_core_param_if.slave bus
);
  localparam int DIV_RAW = (SYSTEM_CLOCK + 8 * UART_BAUDRATE)
                         / (16 * UART_BAUDRATE);
  localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DVW       = $clog2(DIV + 1);
  localparam int BCW       = $clog2(DATA_BITS);
  localparam int AW        = $clog2(RX_FIFO_DEPTH);
  localparam int CW        = $clog2(RX_FIFO_DEPTH + 1);
  localparam int EW        = DATA_BITS + 2;
  localparam int STOP_LAST = 16 * STOP_BITS - 1;

  logic [DVW-1:0] div_cnt;
  logic           tick;

  assign tick = (div_cnt == DVW'(DIV - 1));

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DVW'(1);
  end

  typedef enum logic [2:0] {
    T_IDLE, T_ARM, T_START, T_DATA, T_PAR, T_STOP
  } tx_st_t;

  tx_st_t               ts, ts_n;
  logic [4:0]           tt;
  logic [BCW-1:0]       tbit;
  logic [DATA_BITS-1:0] tsh;
  logic                 tpar;
  logic                 t_end;

  assign t_end = tick &&
    (tt == ((ts == T_STOP) ? 5'(STOP_LAST) : 5'd15));

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) ts <= T_IDLE;
    else        ts <= ts_n;
  end

  always_comb begin
    ts_n = ts;
    unique case (ts)
      T_IDLE:  if (bus.tx_valid) ts_n = T_ARM;
      T_ARM:   if (tick) ts_n = T_START;
      T_START: if (t_end) ts_n = T_DATA;
      T_DATA:
        if (t_end && tbit == BCW'(DATA_BITS - 1))
          ts_n = (PARITY != 0) ? T_PAR : T_STOP;
      T_PAR:   if (t_end) ts_n = T_STOP;
      T_STOP:  if (t_end) ts_n = T_IDLE;
      default: ts_n = T_IDLE;
    endcase
  end

  always_comb begin
    tx           = 1'b1;
    bus.tx_ready = (ts == T_IDLE);
    bus.tx_busy  = (ts != T_IDLE);
    unique case (ts)
      T_START: tx = 1'b0;
      T_DATA:  tx = tsh[0];
      T_PAR:   tx = tpar;
      default: tx = 1'b1;
    endcase
  end

  // Word and parity are captured at accept; later tx_data changes are ignored.
  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      tt   <= '0;
      tbit <= '0;
      tsh  <= '0;
      tpar <= 1'b0;
    end else begin
      if (ts == T_IDLE && bus.tx_valid) begin
        tsh  <= bus.tx_data;
        tpar <= (PARITY == 2) ? ~^bus.tx_data : ^bus.tx_data;
      end
      if (ts == T_IDLE || ts == T_ARM || t_end) tt <= '0;
      else if (tick)                             tt <= tt + 5'd1;
      if (ts != T_DATA) tbit <= '0;
      else if (t_end) begin
        tbit <= tbit + BCW'(1);
        tsh  <= tsh >> 1;
      end
    end
  end

  logic rx_s1, rx_s2;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP
  } rx_st_t;

  rx_st_t               rs, rs_n;
  logic [3:0]           rt;
  logic [BCW-1:0]       rbit;
  logic [DATA_BITS-1:0] rsh;
  logic [1:0]           samp;
  logic                 rpe;
  logic                 maj, mid, r_end, exp_par, push;

  assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s2)
             | (samp[1] & rx_s2);
  assign mid     = tick && (rt == 4'd9);
  assign r_end   = tick && (rt == 4'd15);
  assign exp_par = (PARITY == 2) ? ~^rsh : ^rsh;

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) rs <= R_IDLE;
    else        rs <= rs_n;
  end

  always_comb begin
    rs_n = rs;
    unique case (rs)
      R_IDLE:  if (tick && !rx_s2) rs_n = R_START;
      R_START:
        if (mid && maj) rs_n = R_IDLE;
        else if (r_end) rs_n = R_DATA;
      R_DATA:
        if (r_end && rbit == BCW'(DATA_BITS - 1))
          rs_n = (PARITY != 0) ? R_PAR : R_STOP;
      R_PAR:   if (r_end) rs_n = R_STOP;
      R_STOP:  if (mid) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end

  always_comb begin
    push = (rs == R_STOP) && mid;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      rt   <= '0;
      rbit <= '0;
      rsh  <= '0;
      samp <= '0;
      rpe  <= 1'b0;
    end else begin
      if (rs == R_IDLE || r_end) rt <= '0;
      else if (tick)             rt <= rt + 4'd1;
      if (tick && rt == 4'd7) samp[0] <= rx_s2;
      if (tick && rt == 4'd8) samp[1] <= rx_s2;
      if (rs == R_DATA && mid) rsh <= {maj, rsh[DATA_BITS-1:1]};
      if (rs != R_DATA) rbit <= '0;
      else if (r_end)   rbit <= rbit + BCW'(1);
      if (rs == R_IDLE)             rpe <= 1'b0;
      else if (rs == R_PAR && mid)  rpe <= maj ^ exp_par;
    end
  end

  logic [EW-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          ovr, full, pop, wr;

  assign full = (cnt == CW'(RX_FIFO_DEPTH));
  assign pop  = bus.rx_valid && bus.rx_ready;
  assign wr   = push && (!full || pop);

  always_ff @(posedge system_clk) begin
    if (wr) mem[wp] <= {~maj, rpe, rsh};
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovr <= 1'b0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      unique case ({wr, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // A new overrun outranks a simultaneous clear.
      if (push && full && !pop) ovr <= 1'b1;
      else if (bus.rx_err_clr)  ovr <= 1'b0;
    end
  end

  assign bus.rx_valid      = (cnt != '0);
  assign bus.rx_frame_err  = mem[rp][EW-1];
  assign bus.rx_parity_err = mem[rp][EW-2];
  assign bus.rx_data       = mem[rp][DATA_BITS-1:0];
  assign bus.rx_overrun    = ovr;
  assign bus.rx_fifo_count = cnt;
endmodule
